// File: rtl/uart_pkg.sv
// Shared UART types: line configuration, TX FSM states, request timing default.
// Parity helper folds only the configured number of data bits.
package uart_pkg;

  localparam logic [1:0] DW_5BIT = 2'd0;
  localparam logic [1:0] DW_6BIT = 2'd1;
  localparam logic [1:0] DW_7BIT = 2'd2;
  localparam logic [1:0] DW_8BIT = 2'd3;

  localparam logic [1:0] NO_PARITY = 2'd0;
  localparam logic [1:0] EVEN      = 2'd1;
  localparam logic [1:0] ODD       = 2'd2;

  localparam logic [1:0] SB_1BIT = 2'd0;
  localparam logic [1:0] SB_2BIT = 2'd1;

  // 10 ms of line-low at 100 MHz
  localparam int COUNT_10MS = 1_000_000;

  typedef struct packed {
    logic [1:0] data_width;
    logic [1:0] parity_mode;
    logic [1:0] stop_bits;
  } uart_config_s;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, DATA, PARITY, STOP, REQ
  } uart_tx_fsm_e;

  function automatic logic parity_en(uart_config_s c);
    return (c.parity_mode == EVEN) || (c.parity_mode == ODD);
  endfunction

  function automatic logic frame_parity(logic [7:0] d, uart_config_s c);
    logic [7:0] mask;
    logic       p;
    mask = 8'hFF >> (2'd3 - c.data_width);
    p    = ^(d & mask);
    return (c.parity_mode == ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_req_timer.sv
// Counts REQ_CYCLES clocks after a start pulse; done_o is high on the final cycle.
// Latency: done_o asserts REQ_CYCLES cycles after start_i (inclusive); no backpressure.
// Restarting while active reloads the count.
module uart_tx_req_timer #(
  parameter int REQ_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic done_o
);

  localparam int CW = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REQ_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          active_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= LAST;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART TX engine: pops FWFT FIFO bytes and frames them (start, data LSB-first, parity, stop).
// Latency: pop -> start bit on the next baud tick; config requests hold tx_o low REQ_CYCLES clocks.
// Backpressure: pops only from IDLE; optional TX_BREAK_EN adds break_i to force a line break in IDLE.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int REQ_CYCLES = COUNT_10MS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  uart_config_s config_i,
  input  logic         config_req_mst_i,
  input  logic         tx_fifo_empty_i,
  input  logic [7:0]   data_tx_i,
`ifdef TX_BREAK_EN
  input  logic         break_i,
`endif
  output logic         tx_fifo_read_o,
  output logic         tx_o,
  output logic         tx_done_o,
  output logic         req_done_o,
  output logic         busy_o
);

  uart_tx_fsm_e state;
  uart_config_s cfg_q;
  logic [7:0]   shift_q;
  logic         par_q;
  logic [2:0]   bit_cnt;
  logic         stop_cnt;
  logic         req_armed;
  logic         req_start;
  logic         req_done_w;
  logic [2:0]   last_bit;
  logic         last_stop;

  assign req_start = (state == IDLE) && config_req_mst_i && req_armed;
  assign last_bit  = {1'b1, cfg_q.data_width};
  assign last_stop = (cfg_q.stop_bits == SB_2BIT);

  uart_tx_req_timer #(.REQ_CYCLES(REQ_CYCLES)) u_req_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (req_start),
    .done_o  (req_done_w)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cfg_q          <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      req_armed      <= 1'b1;
      tx_fifo_read_o <= 1'b0;
      tx_o           <= 1'b1;
      tx_done_o      <= 1'b0;
      req_done_o     <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      tx_fifo_read_o <= 1'b0;
      tx_done_o      <= 1'b0;
      req_done_o     <= 1'b0;
      // Re-arm only once the master drops the request level.
      if (!config_req_mst_i) req_armed <= 1'b1;
      case (state)
        IDLE: begin
          if (req_start) begin
            state     <= REQ;
            req_armed <= 1'b0;
            tx_o      <= 1'b0;
            busy_o    <= 1'b1;
          end
`ifdef TX_BREAK_EN
          else if (break_i) begin
            tx_o   <= 1'b0;
            busy_o <= 1'b1;
          end
`endif
          else if (!tx_fifo_empty_i) begin
            tx_fifo_read_o <= 1'b1;
            shift_q        <= data_tx_i;
            cfg_q          <= config_i;
            par_q          <= frame_parity(data_tx_i, config_i);
            bit_cnt        <= '0;
            stop_cnt       <= 1'b0;
            state          <= LOAD;
            tx_o           <= 1'b1;
            busy_o         <= 1'b1;
          end else begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        LOAD: if (tick_i) begin
          state <= START;
          tx_o  <= 1'b0;
        end
        START: if (tick_i) begin
          state   <= DATA;
          bit_cnt <= '0;
          tx_o    <= shift_q[0];
        end
        DATA: if (tick_i) begin
          shift_q <= {1'b0, shift_q[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == last_bit) begin
            stop_cnt <= 1'b0;
            if (parity_en(cfg_q)) begin
              state <= PARITY;
              tx_o  <= par_q;
            end else begin
              state <= STOP;
              tx_o  <= 1'b1;
            end
          end else begin
            tx_o <= shift_q[1];
          end
        end
        PARITY: if (tick_i) begin
          state    <= STOP;
          stop_cnt <= 1'b0;
          tx_o     <= 1'b1;
        end
        STOP: if (tick_i) begin
          if (stop_cnt == last_stop) begin
            state     <= IDLE;
            tx_done_o <= 1'b1;
            busy_o    <= 1'b0;
            tx_o      <= 1'b1;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        REQ: if (req_done_w) begin
          state      <= IDLE;
          req_done_o <= 1'b1;
          busy_o     <= 1'b0;
          tx_o       <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: FIFO model, 16-clock baud tick, scoreboard of expected line activity.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int REQ_T = 100;
  localparam int BIT_T = 16;

  typedef struct {
    bit          is_req;
    int          nbits;
    logic [11:0] bits;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         tick_i = 1'b0;
  uart_config_s config_i;
  logic         config_req_mst_i = 1'b0;
  logic         tx_fifo_empty_i = 1'b1;
  logic [7:0]   data_tx_i = 8'h00;
  logic         tx_fifo_read_o, tx_o, tx_done_o, req_done_o, busy_o;

  int   checks = 0;
  int   passes = 0;
  int   done_cnt = 0;
  int   reqd_cnt = 0;
  int   read_cnt = 0;
  int   tick_cnt = 0;
  bit   mon_en = 1'b1;
  bit   mon_busy = 1'b0;
  logic prev_tx = 1'b1;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];

  uart_transmitter #(.REQ_CYCLES(REQ_T)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .tick_i           (tick_i),
    .config_i         (config_i),
    .config_req_mst_i (config_req_mst_i),
    .tx_fifo_empty_i  (tx_fifo_empty_i),
    .data_tx_i        (data_tx_i),
`ifdef TX_BREAK_EN
    .break_i          (1'b0),
`endif
    .tx_fifo_read_o   (tx_fifo_read_o),
    .tx_o             (tx_o),
    .tx_done_o        (tx_done_o),
    .req_done_o       (req_done_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic uart_config_s mk_cfg(logic [1:0] dw, logic [1:0] pm, logic [1:0] sb);
    uart_config_s c;
    c.data_width  = dw;
    c.parity_mode = pm;
    c.stop_bits   = sb;
    return c;
  endfunction

  function automatic exp_t mk_frame(logic [7:0] d, uart_config_s c);
    exp_t e;
    int   n;
    int   idx;
    logic p;
    n       = 5 + int'(c.data_width);
    e.is_req = 1'b0;
    e.bits   = '1;
    e.bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.bits[1+i] = d[i];
      p = p ^ d[i];
    end
    idx = 1 + n;
    if (c.parity_mode == EVEN || c.parity_mode == ODD) begin
      e.bits[idx] = (c.parity_mode == ODD) ? ~p : p;
      idx++;
    end
    idx = idx + ((c.stop_bits == SB_2BIT) ? 2 : 1);
    e.nbits = idx;
    return e;
  endfunction

  function automatic exp_t mk_req();
    exp_t e;
    e.is_req = 1'b1;
    e.nbits  = 0;
    e.bits   = '0;
    return e;
  endfunction

  task automatic fifo_push(logic [7:0] d);
    fifo_q.push_back(d);
    tx_fifo_empty_i = 1'b0;
    data_tx_i       = fifo_q[0];
  endtask

  // Baud tick and FIFO/strobe bookkeeping, all updated away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt == BIT_T - 1) ? 0 : tick_cnt + 1;
      tick_i   = (tick_cnt == 0);
      if (tx_done_o)  done_cnt++;
      if (req_done_o) reqd_cnt++;
      if (tx_fifo_read_o) begin
        read_cnt++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        tx_fifo_empty_i = (fifo_q.size() == 0);
        data_tx_i       = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      end
    end
  end

  // Line monitor: each falling edge of tx_o must match the next scoreboard entry.
  initial begin
    exp_t e;
    int   n;
    bit   ok;
    bit   aborted;
    logic bad_val;
    forever begin
      @(negedge clk);
      if (mon_en && prev_tx === 1'b1 && tx_o === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_low: got tx_o=0 with nothing expected at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (e.is_req) begin
            n = 1;
            while (n <= REQ_T + 20 && mon_en) begin
              @(negedge clk);
              if (tx_o === 1'b0) n++;
              else break;
            end
            checks++;
            if (n !== REQ_T) $display("FAIL req_len: got %0d low cycles want %0d", n, REQ_T);
            else passes++;
            checks++;
            if (req_done_o !== 1'b1) $display("FAIL req_done_timing: got %b want 1", req_done_o);
            else passes++;
          end else begin
            aborted = 1'b0;
            for (int k = 0; k < e.nbits && !aborted; k++) begin
              ok = 1'b1;
              bad_val = 1'bx;
              for (int s = 0; s < BIT_T; s++) begin
                if (k > 0 || s > 0) @(negedge clk);
                if (!mon_en) begin
                  aborted = 1'b1;
                  break;
                end
                if (tx_o !== e.bits[k] && ok) begin
                  ok = 1'b0;
                  bad_val = tx_o;
                end
              end
              if (!aborted) begin
                checks++;
                if (!ok) $display("FAIL frame_bit%0d: got %b want %b", k, bad_val, e.bits[k]);
                else passes++;
              end
            end
            if (!aborted) begin
              @(negedge clk);
              checks++;
              if (tx_done_o !== 1'b1) $display("FAIL done_timing: got %b want 1", tx_done_o);
              else passes++;
            end
          end
        end
        mon_busy = 1'b0;
      end
      prev_tx = tx_o;
    end
  end

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy && !busy_o && tx_fifo_empty_i) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) $display("FAIL %s_timeout: got pending=%0d want 0", name, exp_q.size());
    else passes++;
  endtask

  task automatic wait_read(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_fifo_read_o) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL %s_pop_timeout: got no pop want pop", name);
    else passes++;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_o !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx_o); else passes++;
    checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else passes++;
    checks++; if (tx_fifo_read_o !== 1'b0) $display("FAIL rst_read: got %b want 0", tx_fifo_read_o); else passes++;
    checks++; if (tx_done_o !== 1'b0) $display("FAIL rst_done: got %b want 0", tx_done_o); else passes++;
    checks++; if (req_done_o !== 1'b0) $display("FAIL rst_req_done: got %b want 0", req_done_o); else passes++;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input uart_config_s c,
                            input bit change_cfg);
    int d0 = done_cnt;
    int r0 = read_cnt;
    config_i = c;
    exp_q.push_back(mk_frame(d, c));
    fifo_push(d);
    if (change_cfg) begin
      wait_read(name);
      config_i = mk_cfg(DW_8BIT, NO_PARITY, SB_1BIT);
    end
    wait_idle(name, 1000);
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL %s_done_cnt: got %0d want 1", name, done_cnt - d0);
    else passes++;
    checks++;
    if (read_cnt - r0 !== 1) $display("FAIL %s_read_cnt: got %0d want 1", name, read_cnt - r0);
    else passes++;
  endtask

  task automatic test_req_midframe();
    int q0 = reqd_cnt;
    config_i = mk_cfg(DW_8BIT, NO_PARITY, SB_1BIT);
    exp_q.push_back(mk_frame(8'h3C, config_i));
    exp_q.push_back(mk_req());
    fifo_push(8'h3C);
    wait_read("midreq");
    repeat (40) @(negedge clk);
    config_req_mst_i = 1'b1;
    wait_idle("midreq", 1500);
    repeat (300) @(negedge clk);
    checks++;
    if (reqd_cnt - q0 !== 1) $display("FAIL midreq_req_cnt: got %0d want 1", reqd_cnt - q0);
    else passes++;
    checks++;
    if (tx_o !== 1'b1) $display("FAIL midreq_no_retrigger: got %b want 1", tx_o);
    else passes++;
    config_req_mst_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int q0 = reqd_cnt;
    logic [7:0] bytes [3];
    bytes[0] = 8'hFF;
    bytes[1] = 8'h00;
    bytes[2] = 8'h81;
    config_i = mk_cfg(DW_8BIT, EVEN, SB_1BIT);
    exp_q.push_back(mk_req());
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_frame(bytes[i], config_i));
    for (int i = 0; i < 3; i++) fifo_push(bytes[i]);
    config_req_mst_i = 1'b1;
    wait_idle("b2b", 3000);
    checks++;
    if (done_cnt - d0 !== 3) $display("FAIL b2b_done_cnt: got %0d want 3", done_cnt - d0);
    else passes++;
    checks++;
    if (reqd_cnt - q0 !== 1) $display("FAIL b2b_req_cnt: got %0d want 1", reqd_cnt - q0);
    else passes++;
    config_req_mst_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bit seen = 1'b0;
    mon_en   = 1'b0;
    config_i = mk_cfg(DW_8BIT, NO_PARITY, SB_1BIT);
    fifo_push(8'h3C);
    wait_read("rstmid");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL rstmid_start_timeout: got no start bit want start bit");
    else passes++;
    repeat (BIT_T + 3 * BIT_T + 8) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checks++; if (tx_o !== 1'b1) $display("FAIL rstmid_tx: got %b want 1", tx_o); else passes++;
    checks++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_o); else passes++;
    checks++;
    if (dut.state !== IDLE) $display("FAIL rstmid_state: got %0d want %0d", dut.state, IDLE);
    else passes++;
    rst_i  = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    test_frame("after_rst", 8'h96, mk_cfg(DW_8BIT, NO_PARITY, SB_1BIT), 1'b0);
  endtask

  initial begin
    config_i = mk_cfg(DW_8BIT, NO_PARITY, SB_1BIT);
    test_reset();
    test_frame("8n1", 8'hA5, mk_cfg(DW_8BIT, NO_PARITY, SB_1BIT), 1'b0);
    test_frame("7e2", 8'h53, mk_cfg(DW_7BIT, EVEN, SB_2BIT), 1'b1);
    test_frame("5o1", 8'h1F, mk_cfg(DW_5BIT, ODD, SB_1BIT), 1'b0);
    test_frame("6rsv", 8'h2A, mk_cfg(DW_6BIT, 2'd3, 2'd3), 1'b0);
    test_req_midframe();
    test_back_to_back();
    test_reset_midframe();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial TX engine of the UART, the transmit-side counterpart of the main controller's configuration and data flow.
- Pops bytes from the TX FIFO and serialises them on tx_o as start, data (LSB first), optional parity and stop bits, using the live uart_config_s.
- Generates the configuration-request line condition (TX held low for the request duration) and reports frame completion (tx_done_o) and request completion (req_done_o) to the main controller.
- Bit timing comes from the external baud rate generator's one-cycle tick.

Parameters:
- REQ_CYCLES, 1_000_000: clock cycles tx_o is held low for a configuration request (10 ms at 100 MHz).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- tick_i  in  1  baud tick; one clk_i-cycle pulse per bit period.
- config_i  in  uart_config_s  data_width / parity_mode / stop_bits.
- config_req_mst_i  in  1  level request to send a configuration request.
- tx_fifo_empty_i  in  1  TX FIFO empty flag.
- data_tx_i  in  8  TX FIFO head word (first-word-fall-through, valid while !tx_fifo_empty_i).
- tx_fifo_read_o  out  1  one-cycle pop strobe.
- tx_o  out  1  serial line; idle high.
- tx_done_o  out  1  one-cycle pulse, frame finished.
- req_done_o  out  1  one-cycle pulse, configuration request finished.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- One clock, clk_i. Reset is synchronous on rst_i, active-high, and takes effect from any state, including mid-frame or mid-request.
- Reset values: state=IDLE, tx_o=1, tx_fifo_read_o=0, tx_done_o=0, req_done_o=0, busy_o=0. Counters, shift register and config snapshot are cleared. req_armed=1.
- FSM states: IDLE, LOAD, START, DATA, PARITY, STOP, REQ.
- IDLE, priority order:
  - config_req_mst_i && req_armed: go to REQ and clear req_armed.
  - else !tx_fifo_empty_i: assert tx_fifo_read_o for one cycle, latch data_tx_i and snapshot config_i, go to LOAD.
  - req_armed is set again whenever config_req_mst_i is sampled low.
- LOAD: wait for tick_i, then go to START. The start bit is therefore aligned to a tick.
- Bit advance: every transition from START, DATA, PARITY or STOP happens only on a cycle with tick_i=1. Each bit lasts exactly one tick period.
- START: tx_o=0. On tick go to DATA with bit counter=0.
- DATA:
  - tx_o = shift[0]. On tick shift right and increment the counter.
  - After N bits (DW_5BIT..DW_8BIT gives N=5..8) go to PARITY if parity is enabled, else STOP.
  - Unused upper data bits are never sent.
- PARITY:
  - tx_o = XOR of the N data bits for EVEN, its inverse for ODD.
  - Any other parity_mode value means no parity; PARITY is skipped.
- STOP:
  - tx_o=1 for 1 tick period (SB_1BIT) or 2 tick periods (SB_2BIT). Reserved encodings are treated as 1 stop bit.
  - On the final stop tick: pulse tx_done_o and go to IDLE. A new byte can be popped on the next cycle.
- Config snapshot: config_i changes during a frame do not affect that frame.
- REQ:
  - tx_o=0. A cycle counter runs from 0 independently of tick_i.
  - When the counter reaches REQ_CYCLES-1: pulse req_done_o and go to IDLE.
  - The FIFO is not read during REQ.
- Simultaneous events:
  - A request and a non-empty FIFO together in IDLE: the request wins.
  - A request arriving mid-frame waits until the frame completes.
  - A tick in the same cycle as a FIFO pop is ignored; LOAD waits for the next tick.
- Counter width: $clog2(REQ_CYCLES). Bit counter: 3 bits. Stop counter: 1 bit.

Optional Feature:
- Macro: TX_BREAK_EN.
- Defined:
  - Adds input port break_i (1 bit).
  - In IDLE with no armed request, break_i=1 drives tx_o=0 and blocks FIFO pops while held; busy_o=1 while breaking.
  - Release returns tx_o=1 on the next cycle.
  - break_i is ignored outside IDLE.
- Undefined: no port and no break logic; IDLE always drives tx_o=1.

Decomposition:
- UART_pkg holds:
  - uart_config_s, DW_5BIT..DW_8BIT, EVEN/ODD parity encodings, SB_1BIT/SB_2BIT.
  - New enum uart_tx_fsm_e.
  - New constant COUNT_10MS, used as the default source for REQ_CYCLES at instantiation.
- One natural sub-module: uart_tx_req_timer (REQ_CYCLES down-counter, start/done handshake).
- Everything else is inline.

Test Plan:
- 8N1, byte 0xA5, tick every 16 clk → tx_o shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. One tx_done_o pulse. Exactly one tx_fifo_read_o.
- 7 data bits, EVEN parity, 2 stop bits, byte 0x53 → data 1,1,0,0,1,0,1, parity=0, then two stop bits (two 1s). Bit 7 is never sent.
- ODD parity, 5 data bits, byte 0x1F → parity bit 0 (five ones), frame of 8 bit periods.
- config_req_mst_i rises mid-frame, REQ_CYCLES=100 → the frame completes first, then tx_o=0 for exactly 100 cycles. req_done_o pulses once. No re-trigger until the request is deasserted.
- FIFO holds 3 bytes; a 0xFF request and the FIFO both pending in IDLE → request serviced first, then 3 back-to-back frames with 3 tx_done_o pulses.
- rst_i asserted during DATA bit 3 → next cycle: tx_o=1, busy_o=0, state IDLE. The next byte is framed from its start bit.
